// File: rtl/glip_uart_arb_pkg.sv
// Shared types and limits for the GLIP UART round-robin transmit arbiter.
package glip_uart_arb_pkg;

  localparam int CHAN_BITS       = 4;
  localparam int LEN_BITS        = 4;
  localparam int MAX_CHANNELS    = 16;
  localparam int MAX_BURST_LIMIT = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_HEADER = 2'd2,
    S_DRAIN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/glip_uart_rr_pick.sv
// Rotating-priority picker: first requester after 'last', wrapping modulo CHANNELS.
module glip_uart_rr_pick #(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [3:0]          last,
  output logic [3:0]          gnt_idx,
  output logic                any
);

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    int c;
    c       = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = CHANNELS; i >= 1; i--) begin
      c = (int'(last) + i) % CHANNELS;
      if (req[c]) begin
        gnt_idx = 4'(c);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glip_uart_rr_arbiter.sv
// Round-robin arbiter gathering byte bursts from CHANNELS requesters and
// forwarding them to the UART TX FIFO as {channel, len-1} header plus payload.
//
// state    | meaning
// IDLE     | waiting for any requester, picks next channel round-robin
// GATHER   | collecting up to MAX_BURST bytes from the granted channel
// HEADER   | presenting {grant_chan, count-1}
// DRAIN    | presenting buffered payload bytes
module glip_uart_rr_arbiter
  import glip_uart_arb_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CHANNELS*8-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            grant_chan,
  output logic                  busy
);

  localparam logic [4:0] BURST_LEN = 5'(MAX_BURST);

  arb_state_e                    state;
  logic [CHAN_BITS-1:0]          grant_q;
  logic [CHAN_BITS-1:0]          last_grant;
  logic [4:0]                    count;
  logic [4:0]                    rd_ptr;
  logic [7:0]                    byte_buf [MAX_BURST_LIMIT];

  logic [MAX_CHANNELS-1:0]       valid_pad;
  logic [MAX_CHANNELS*8-1:0]     data_pad;
  logic [MAX_CHANNELS-1:0]       rdy_full;
  logic                          cur_valid;
  logic [7:0]                    cur_byte;
  logic                          can_take;
  logic                          accept;
  logic [3:0]                    pick_idx;
  logic                          pick_any;

  // Zero-pad so a 4-bit channel index is always in range whatever CHANNELS is.
  assign valid_pad = MAX_CHANNELS'(in_valid);
  assign data_pad  = (MAX_CHANNELS*8)'(in_data);
  assign rdy_full  = MAX_CHANNELS'(1) << grant_q;
  assign cur_valid = valid_pad[grant_q];
  assign cur_byte  = data_pad[{grant_q, 3'b000} +: 8];
  assign can_take  = (state == S_GATHER) && (count < BURST_LEN);
  assign accept    = can_take && cur_valid;

  glip_uart_rr_pick #(
    .CHANNELS(CHANNELS)
  ) u_pick (
    .req     (in_valid),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      last_grant <= 4'(CHANNELS - 1);
      count      <= '0;
      rd_ptr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            count   <= '0;
            state   <= S_GATHER;
          end
        end
        S_GATHER: begin
          if (accept) begin
            count <= count + 5'd1;
            if (count + 5'd1 == BURST_LEN) state <= S_HEADER;
          end else if (count >= BURST_LEN || (!cur_valid && count != 5'd0)) begin
            state <= S_HEADER;
          end else if (!cur_valid) begin
            // Requester vanished before sending anything: no empty burst.
            state      <= S_IDLE;
            last_grant <= grant_q;
          end
        end
        S_HEADER: begin
          if (out_ready) begin
            rd_ptr <= '0;
            state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == count - 5'd1) begin
              state      <= S_IDLE;
              last_grant <= grant_q;
            end else begin
              rd_ptr <= rd_ptr + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) byte_buf[count[3:0]] <= cur_byte;
  end

  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    if (can_take) in_ready = rdy_full[CHANNELS-1:0];
    case (state)
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = {grant_q, LEN_BITS'(count - 5'd1)};
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = byte_buf[rd_ptr[3:0]];
      end
      default: ;
    endcase
  end

  assign grant_chan = grant_q;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_glip_uart_rr_arbiter.sv
// Directed bench for glip_uart_rr_arbiter: a 4ch/16-byte instance plus a 4ch/2-byte instance for round-robin.
module tb_glip_uart_rr_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  grant_chan;
  logic        busy;

  logic [31:0] in_data2 = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
  logic [3:0]  in_valid2 = '0;
  logic [3:0]  in_ready2;
  logic [7:0]  out_data2;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [3:0]  grant_chan2;
  logic        busy2;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] src_q [4][$];
  logic [7:0] out_q [$];
  logic [7:0] out2_q [$];
  logic [3:0] en = 4'hF;
  logic       or_toggle = 1'b0;
  logic       rr_en = 1'b0;
  logic       hold_valid = 1'b0;
  logic [7:0] hold_data = '0;
  int         cyc = 0;
  int         first_ov = -1;
  int         last_rdy2 = -1;

  always #5 clk = ~clk;

  glip_uart_rr_arbiter #(.CHANNELS(4), .MAX_BURST(16)) dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_chan(grant_chan), .busy(busy)
  );

  glip_uart_rr_arbiter #(.CHANNELS(4), .MAX_BURST(2)) dut2 (
    .clk(clk), .rstn(rstn),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .grant_chan(grant_chan2), .busy(busy2)
  );

  // One clock: drive sources, sample outputs, cross the edge, retire handshakes.
  task automatic step();
    logic [3:0] fire;
    for (int c = 0; c < 4; c++) begin
      in_valid[c] = en[c] && (src_q[c].size() > 0);
      in_data[c*8 +: 8] = (src_q[c].size() > 0) ? src_q[c][0] : 8'h00;
    end
    out_ready = or_toggle ? ~out_ready : 1'b1;
    in_valid2 = rr_en ? 4'hF : 4'h0;
    #1;
    if (hold_valid) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== hold_data) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%b data=%h, want valid=1 data=%h", out_valid, out_data, hold_data);
      end
    end
    vectors++;
    if ($countones(in_ready) > 1) begin
      miscompares++;
      $display("FAIL in_ready_onehot: got %b, want at most one bit", in_ready);
    end
    fire = in_valid & in_ready;
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (out_valid2 && out_ready2) out2_q.push_back(out_data2);
    hold_valid = out_valid & ~out_ready;
    hold_data  = out_data;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (in_ready[2]) last_rdy2 = cyc;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) if (fire[c]) void'(src_q[c].pop_front());
    cyc++;
  endtask

  task automatic run_until_out(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (out_q.size() < n && k < budget) begin
      step();
      k++;
    end
    vectors++;
    if (out_q.size() < n) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d out bytes, want %0d", name, out_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    step();
    while (busy && k < budget) begin
      step();
      k++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got busy=%b, want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    vectors += 6;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 4'h0) begin miscompares++; $display("FAIL reset_in_ready: got %h want 0", in_ready); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    if (grant_chan !== 4'h0) begin miscompares++; $display("FAIL reset_grant: got %h want 0", grant_chan); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (out_valid2 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid2: got %b want 0", out_valid2); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_single_burst();
    out_q.delete();
    for (int i = 0; i < 16; i++) src_q[2].push_back(8'(8'h10 + i));
    cyc = 0; first_ov = -1; last_rdy2 = -1;
    run_until_out(17, 60, "single");
    vectors += 19;
    if (out_q.size() > 0 && out_q[0] !== 8'h2F) begin miscompares++; $display("FAIL single_header: got %h want 2F", out_q[0]); end
    for (int i = 0; i < 16; i++) begin
      if (i + 1 >= out_q.size() || out_q[i+1] !== 8'(8'h10 + i)) begin
        miscompares++;
        $display("FAIL single_payload[%0d]: got %h want %h", i, (i + 1 < out_q.size()) ? out_q[i+1] : 8'hxx, 8'(8'h10 + i));
      end
    end
    if (first_ov != 17) begin miscompares++; $display("FAIL single_header_cycle: got %0d want 17", first_ov); end
    if (last_rdy2 != 16) begin miscompares++; $display("FAIL single_last_ready_cycle: got %0d want 16", last_rdy2); end
    wait_idle(10, "single");
    vectors++;
    if (grant_chan !== 4'h2) begin miscompares++; $display("FAIL single_grant: got %h want 2", grant_chan); end
  endtask

  task automatic test_short_burst();
    out_q.delete();
    src_q[1].push_back(8'hA5);
    src_q[1].push_back(8'h5A);
    run_until_out(3, 20, "short");
    vectors += 3;
    if (out_q.size() > 0 && out_q[0] !== 8'h11) begin miscompares++; $display("FAIL short_header: got %h want 11", out_q[0]); end
    if (out_q.size() > 1 && out_q[1] !== 8'hA5) begin miscompares++; $display("FAIL short_b0: got %h want A5", out_q[1]); end
    if (out_q.size() > 2 && out_q[2] !== 8'h5A) begin miscompares++; $display("FAIL short_b1: got %h want 5A", out_q[2]); end
    wait_idle(5, "short");
    vectors++;
    if (out_q.size() != 3) begin miscompares++; $display("FAIL short_count: got %0d want 3", out_q.size()); end
  endtask

  task automatic test_backpressure();
    out_q.delete();
    or_toggle = 1'b1;
    for (int i = 0; i < 16; i++) src_q[0].push_back(8'(8'h30 + i));
    run_until_out(17, 150, "bp");
    wait_idle(10, "bp");
    or_toggle = 1'b0;
    vectors += 18;
    if (out_q.size() != 17) begin miscompares++; $display("FAIL bp_count: got %0d want 17", out_q.size()); end
    if (out_q.size() > 0 && out_q[0] !== 8'h0F) begin miscompares++; $display("FAIL bp_header: got %h want 0F", out_q[0]); end
    for (int i = 0; i < 16; i++) begin
      if (i + 1 >= out_q.size() || out_q[i+1] !== 8'(8'h30 + i)) begin
        miscompares++;
        $display("FAIL bp_payload[%0d]: got %h want %h", i, (i + 1 < out_q.size()) ? out_q[i+1] : 8'hxx, 8'(8'h30 + i));
      end
    end
  endtask

  task automatic test_valid_drop();
    logic [7:0] exp [4];
    exp = '{8'h00, 8'h44, 8'h20, 8'h55};
    out_q.delete();
    src_q[3].push_back(8'h77);
    en = 4'b1000;
    step();
    en = 4'b0000;
    src_q[3].delete();
    first_ov = -1;
    for (int i = 0; i < 3; i++) step();
    vectors += 3;
    if (first_ov != -1) begin miscompares++; $display("FAIL drop_no_output: got out_valid at step %0d, want none", first_ov); end
    if (grant_chan !== 4'h3) begin miscompares++; $display("FAIL drop_grant: got %h want 3", grant_chan); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_busy: got %b want 0", busy); end
    // last_grant=3 means channel 0 must beat channel 2.
    en = 4'hF;
    src_q[0].push_back(8'h44);
    src_q[2].push_back(8'h55);
    run_until_out(4, 40, "drop");
    wait_idle(10, "drop");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL drop_seq[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] hdr [5];
    int k;
    hdr = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h01};
    out2_q.delete();
    rr_en = 1'b1;
    k = 0;
    while (out2_q.size() < 15 && k < 200) begin
      step();
      k++;
    end
    rr_en = 1'b0;
    vectors++;
    if (out2_q.size() < 15) begin miscompares++; $display("FAIL rr_timeout: got %0d bytes want 15", out2_q.size()); end
    for (int b = 0; b < 5; b++) begin
      vectors += 3;
      if (3*b >= out2_q.size() || out2_q[3*b] !== hdr[b]) begin
        miscompares++;
        $display("FAIL rr_header[%0d]: got %h want %h", b, (3*b < out2_q.size()) ? out2_q[3*b] : 8'hxx, hdr[b]);
      end
      for (int j = 1; j <= 2; j++) begin
        if (3*b + j >= out2_q.size() || out2_q[3*b+j] !== {4'hC, hdr[b][7:4]}) begin
          miscompares++;
          $display("FAIL rr_payload[%0d][%0d]: got %h want %h", b, j, (3*b + j < out2_q.size()) ? out2_q[3*b+j] : 8'hxx, {4'hC, hdr[b][7:4]});
        end
      end
    end
    k = 0;
    while (busy2 && k < 20) begin
      step();
      k++;
    end
    vectors++;
    if (busy2 !== 1'b0) begin miscompares++; $display("FAIL rr_idle: got busy2=%b want 0", busy2); end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] exp [4];
    exp = '{8'h00, 8'hE0, 8'h10, 8'h99};
    out_q.delete();
    for (int i = 0; i < 16; i++) src_q[1].push_back(8'(8'h80 + i));
    run_until_out(6, 40, "rst");
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_in_drain: got out_valid=%b want 1", out_valid); end
    rstn = 1'b0;
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 4'h0) begin miscompares++; $display("FAIL rst_in_ready: got %h want 0", in_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    out_q.delete();
    hold_valid = 1'b0;
    src_q[1].delete();
    src_q[0].push_back(8'hE0);
    src_q[1].push_back(8'h99);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_until_out(4, 40, "rst_after");
    wait_idle(10, "rst_after");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= out_q.size() || out_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rst_seq[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_short_burst();
    test_backpressure();
    test_valid_drop();
    test_round_robin();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/glip_uart_rr_arbiter.md
Name: glip_uart_rr_arbiter

Overview:
- Shares the single byte-wide GLIP UART transmit FIFO (fifo_out_*) between CHANNELS independent byte-stream requesters.
- Grants requesters round-robin and gathers up to MAX_BURST bytes from the granted channel into an internal buffer.
- Then emits one header byte {channel, count-1} followed by the buffered bytes, so the host can demultiplex.
- Sits between demo/user logic and the UART toplevel's fifo_out port; all handshakes are valid/ready.

Parameters:
- CHANNELS, 4, number of requesters; legal 1..16.
- MAX_BURST, 16, maximum payload bytes per grant; legal 1..16.

Ports:
- clk  in  1  single clock for the whole block.
- rstn  in  1  asynchronous, active-low reset.
- in_data  in  CHANNELS*8  requester bytes; channel c at bits [8c+7:8c].
- in_valid  in  CHANNELS  per-channel byte valid.
- in_ready  out  CHANNELS  per-channel ready; at most one bit high.
- out_data  out  8  byte to UART TX FIFO.
- out_valid  out  1  out_data valid.
- out_ready  in  1  UART TX FIFO accepts byte.
- grant_chan  out  4  currently/last granted channel.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rstn=0): state=IDLE, out_valid=0, in_ready=0, out_data=0, grant_chan=0, busy=0, count=0, rd_ptr=0, last_grant=CHANNELS-1 (channel 0 has first priority).
- Reset mid-operation discards the buffer and any partial burst; nothing is replayed.
- All outputs are functions of registered state only; no combinational path from in_valid/out_ready to any output.
- FSM states: IDLE, GATHER, HEADER, DRAIN.
- IDLE:
  - If any in_valid is high, pick the first valid channel scanning last_grant+1, last_grant+2, … modulo CHANNELS.
  - Register it into grant_chan, clear count, go to GATHER next cycle.
  - With no valid channel, stay in IDLE.
- GATHER:
  - in_ready[grant_chan] = (count < MAX_BURST); all other in_ready bits are 0.
  - On in_valid & in_ready: buf[count] <= byte, count++.
  - Go to HEADER when count reaches MAX_BURST, or when in_valid[grant_chan]=0 with count>0.
  - If in_valid drops with count==0: return to IDLE, set last_grant <= grant_chan, emit nothing.
- HEADER:
  - out_valid=1, out_data={grant_chan[3:0], (count-1)[3:0]}.
  - On out_ready: rd_ptr<=0, go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=buf[rd_ptr].
  - On out_ready with rd_ptr==count-1: go to IDLE, last_grant<=grant_chan.
  - On out_ready otherwise: rd_ptr++.
- out_valid is never deasserted while waiting for out_ready; out_data is stable while out_valid & !out_ready.
- Latency, one channel valid continuously, out_ready=1:
  - cycle 0 IDLE decision;
  - bytes accepted cycles 1..MAX_BURST;
  - header at cycle MAX_BURST+1;
  - payload cycles MAX_BURST+2..2*MAX_BURST+1;
  - next arbitration cycle 2*MAX_BURST+2.
- Fairness: a channel cannot be regranted while another channel with in_valid high is pending at the IDLE decision.
- Width rules:
  - count and rd_ptr are 5 bits;
  - the header length field is count-1 truncated to 4 bits (count is 1..16, so it is exact);
  - channel index uses 4 bits zero-extended.
- CHANNELS=1: grant is always 0; the FSM is otherwise unchanged.

Decomposition:
- Package glip_uart_arb_pkg holds:
  - state enum (IDLE, GATHER, HEADER, DRAIN);
  - header field widths (CHAN_BITS=4, LEN_BITS=4);
  - MAX_CHANNELS=16 and MAX_BURST_LIMIT=16.
- One sub-module, glip_uart_rr_pick: combinational rotate-priority picker.
  - Inputs: req[CHANNELS], last[3:0].
  - Outputs: gnt_idx[3:0], any.
- The buffer is a plain register array inside the top module.

Test Plan:
- Single burst: channel 2 offers bytes 0x10..0x1F continuously, out_ready=1 → out stream 0x2F, 0x10..0x1F; header at cycle 17; in_ready[2] low from cycle 17.
- Short burst: channel 1 offers 0xA5, 0x5A then drops valid → out 0x11, 0xA5, 0x5A; FSM back to IDLE; busy=0.
- Round-robin: all 4 channels always valid with MAX_BURST=2 → header sequence 0x01, 0x11, 0x21, 0x31, 0x01; no channel granted twice in a row.
- Backpressure: out_ready toggles 1/0 every cycle during HEADER/DRAIN → out_data held stable while stalled; no byte lost or duplicated; total 17 out bytes for a 16-byte burst.
- Valid drop at grant: channel 3 pulses in_valid for one cycle in IDLE only → GATHER sees count==0 and returns to IDLE; no out_valid; last_grant=3.
- Async reset mid-DRAIN: assert rstn=0 after 5 payload bytes → out_valid=0, in_ready=0 immediately; after release, the channel 0 request is granted first.
